// File: rtl/nn_defs.sv
// rtl/nn_defs.sv - shared definitions for the neuron and layer blocks
// Purpose: layer sequencer FSM state encoding and the default neuron result width.
// Ports: none (package).
package nn_defs;

    // Default neuron result width, shared by neuron and layer blocks
    localparam int NN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/layer_sequencer_counter.sv
// rtl/layer_sequencer_counter.sv - neuron index counter with clear and increment
// Purpose: index counter 0..N-1; init has priority over inc.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset, clears out
//   init in  synchronous clear
//   inc  in  increment by one
//   out  out current count, $clog2(N) bits
module counter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (init) begin
            out <= '0;
        end else if (inc) begin
            out <= out + 1'b1;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - time-multiplexes one neuron datapath across a layer
// Purpose: launches each of M neurons in turn, captures results (optional ReLU)
//          into an M-entry buffer and holds the layer valid until acknowledged.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         begin a layer (sampled only in IDLE)
//   neuron_start  one-cycle launch pulse to the neuron controller
//   neuron_ready  completion pulse; neuron_out valid in that cycle
//   neuron_idx    neuron currently computed
//   busy          high outside IDLE
//   layer_valid   complete layer held in buffer
//   layer_ack     consumer took the layer
//   rd_addr       buffer read index; rd_data combinational read (0 when out of range)
module layer_sequencer
    import nn_defs::*;
#(
    parameter int M    = 4,
    parameter int W    = NN_W,
    parameter bit RELU = 1'b1,
    localparam int IW  = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          neuron_start,
    input  logic          neuron_ready,
    input  logic [W-1:0]  neuron_out,
    output logic [IW-1:0] neuron_idx,
    output logic          busy,
    output logic          layer_valid,
    input  logic          layer_ack,
    input  logic [IW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    seq_state_t state, state_nxt;

    logic         capture;
    logic         last;
    logic         idx_inc;
    logic         idx_init;
    logic [W-1:0] res_buf [M];

    assign capture  = (state == ST_WAIT) && neuron_ready;
    assign last     = (neuron_idx == IW'(M - 1));
    // Index advances only on a non-final capture, so it never wraps past M-1
    assign idx_inc  = capture && !last;
    assign idx_init = (state == ST_IDLE);

    counter #(.N(M)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .init (idx_init),
        .inc  (idx_inc),
        .out  (neuron_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode the registered state only, so reset drops them asynchronously
    always_comb begin
        state_nxt    = state;
        neuron_start = 1'b0;
        busy         = 1'b1;
        layer_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                neuron_start = 1'b1;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (neuron_ready) state_nxt = last ? ST_DONE : ST_LAUNCH;
            end
            ST_DONE: begin
                layer_valid = 1'b1;
                // ack wins over a simultaneous start; the start is dropped
                if (layer_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) res_buf[i] <= '0;
        end else if (capture) begin
            res_buf[neuron_idx] <= (RELU && neuron_out[W-1]) ? '0 : neuron_out;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < (IW + 1)'(M)) rd_data = res_buf[rd_addr];
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - self-checking bench for layer_sequencer
module tb_layer_sequencer;

    localparam int M  = 4;
    localparam int W  = 16;
    localparam int IW = 2;
    localparam int TP = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          neuron_ready;
    logic [W-1:0]  neuron_out;
    logic          layer_ack;
    logic [IW-1:0] rd_addr;

    logic          ns_r, busy_r, lv_r;
    logic [IW-1:0] idx_r;
    logic [W-1:0]  rd_r;
    logic          ns_n, busy_n, lv_n;
    logic [IW-1:0] idx_n;
    logic [W-1:0]  rd_n;

    always #(TP/2) clk = ~clk;

    layer_sequencer #(.M(M), .W(W), .RELU(1'b1)) dut_r (
        .clk(clk), .rst(rst), .start(start), .neuron_start(ns_r),
        .neuron_ready(neuron_ready), .neuron_out(neuron_out), .neuron_idx(idx_r),
        .busy(busy_r), .layer_valid(lv_r), .layer_ack(layer_ack),
        .rd_addr(rd_addr), .rd_data(rd_r)
    );

    layer_sequencer #(.M(M), .W(W), .RELU(1'b0)) dut_n (
        .clk(clk), .rst(rst), .start(start), .neuron_start(ns_n),
        .neuron_ready(neuron_ready), .neuron_out(neuron_out), .neuron_idx(idx_n),
        .busy(busy_n), .layer_valid(lv_n), .layer_ack(layer_ack),
        .rd_addr(rd_addr), .rd_data(rd_n)
    );

    typedef struct {
        logic [W-1:0] val;
        int           lat;
        logic [W-1:0] exp_relu;
        logic [W-1:0] exp_raw;
    } vec_t;

    vec_t         tbl [8];
    logic [W-1:0] m_r [M];
    logic [W-1:0] m_n [M];
    int           checks = 0;
    int           errors = 0;
    int           n_starts = 0;

    always @(negedge clk) if (ns_r) n_starts++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reads every entry of both instances against the reference model
    task automatic chk_bufs(input string tag);
        for (int i = 0; i < M; i++) begin
            rd_addr = IW'(i);
            #1;
            chk({tag, "_relu_buf"}, {16'h0, rd_r}, {16'h0, m_r[i]});
            chk({tag, "_raw_buf"},  {16'h0, rd_n}, {16'h0, m_n[i]});
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < M; i++) begin
            m_r[i] = '0;
            m_n[i] = '0;
        end
    endtask

    // Drives one layer as the neuron controller would. lat[i] is the number of
    // cycles from the launch cycle to the ready cycle (1 = ready right after launch).
    // abort_at >= 0 asserts rst in the WAIT cycle of that neuron and stops.
    task automatic run_layer(input logic [W-1:0] vals[M], input int lat[M],
                             input bit spur, input bit do_ack, input int abort_at);
        int  s0;
        int  lat_sum;
        time t0;
        bit  ok;
        s0 = n_starts;
        lat_sum = 0;
        t0 = 0;
        if (spur) begin
            neuron_ready = 1'b1;
            neuron_out   = 16'h1234;
            layer_ack    = 1'b1;
            @(negedge clk);
            neuron_ready = 1'b0;
            layer_ack    = 1'b0;
            chk("idle_spurious_busy", {31'h0, busy_r}, 32'h0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < M; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                if (ns_r) ok = 1'b1;
                else @(negedge clk);
            end
            chk("launch_seen", {31'h0, ok}, 32'h1);
            if (!ok) return;
            chk("launch_idx", {30'h0, idx_r}, i);
            if (i == 0) t0 = $time;
            lat_sum += lat[i];
            if (i == abort_at) begin
                @(negedge clk);
                rst = 1'b1;
                clear_model();
                chk_bufs("reset_mid");
                chk("reset_busy", {31'h0, busy_r}, 32'h0);
                chk("reset_nstart", {31'h0, ns_r}, 32'h0);
                chk("reset_idx", {30'h0, idx_r}, 32'h0);
                chk("reset_valid", {31'h0, lv_r}, 32'h0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (spur) begin
                neuron_ready = 1'b1;
                neuron_out   = 16'h1234;
            end
            for (int c = 0; c < lat[i]; c++) begin
                @(negedge clk);
                neuron_ready = 1'b0;
                start        = spur;
            end
            chk("wait_idx_hold", {30'h0, idx_r}, i);
            chk("wait_busy", {31'h0, busy_r}, 32'h1);
            neuron_ready = 1'b1;
            neuron_out   = vals[i];
            start        = 1'b0;
            m_n[i] = vals[i];
            m_r[i] = vals[i][W-1] ? '0 : vals[i];
            @(negedge clk);
            neuron_ready = 1'b0;
        end
        chk("layer_valid_rise", {31'h0, lv_r}, 32'h1);
        chk("raw_layer_valid", {31'h0, lv_n}, 32'h1);
        chk("launch_to_done", 32'(($time - t0) / TP), 32'(lat_sum + M));
        chk("start_pulses", 32'(n_starts - s0), 32'(M));
        chk_bufs("layer");
        if (do_ack) begin
            layer_ack = 1'b1;
            @(negedge clk);
            layer_ack = 1'b0;
            chk("ack_idle", {31'h0, busy_r}, 32'h0);
            chk("ack_valid_drop", {31'h0, lv_r}, 32'h0);
        end
    endtask

    initial begin
        logic [W-1:0] v [M];
        int           l [M];
        int           s0;

        tbl[0] = '{16'd5,    3, 16'd5,    16'd5};
        tbl[1] = '{16'hfffe, 3, 16'd0,    16'hfffe};
        tbl[2] = '{16'd7,    3, 16'd7,    16'd7};
        tbl[3] = '{16'd0,    3, 16'd0,    16'd0};
        tbl[4] = '{16'h8000, 2, 16'd0,    16'h8000};
        tbl[5] = '{16'h7fff, 1, 16'h7fff, 16'h7fff};
        tbl[6] = '{16'hffff, 4, 16'd0,    16'hffff};
        tbl[7] = '{16'h0001, 2, 16'h0001, 16'h0001};

        rst = 1'b1; start = 1'b0; neuron_ready = 1'b0; neuron_out = '0;
        layer_ack = 1'b0; rd_addr = '0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy_r}, 32'h0);
        chk("rst_valid", {31'h0, lv_r}, 32'h0);
        chk("rst_nstart", {31'h0, ns_r}, 32'h0);
        chk("rst_idx", {30'h0, idx_r}, 32'h0);
        chk_bufs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Table layers: compare against the table's own expected columns as well
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < M; i++) begin
                v[i] = tbl[t*M + i].val;
                l[i] = tbl[t*M + i].lat;
            end
            run_layer(v, l, 1'b0, 1'b1, -1);
            for (int i = 0; i < M; i++) begin
                rd_addr = IW'(i);
                #1;
                chk("tbl_relu", {16'h0, rd_r}, {16'h0, tbl[t*M + i].exp_relu});
                chk("tbl_raw",  {16'h0, rd_n}, {16'h0, tbl[t*M + i].exp_raw});
            end
            @(negedge clk);
        end

        // Spurious ready in IDLE/LAUNCH, start pulses in WAIT
        for (int i = 0; i < M; i++) begin
            v[i] = 16'(i * 3 + 1);
            l[i] = 2;
        end
        run_layer(v, l, 1'b1, 1'b0, -1);

        // Held in DONE without ack; start ignored; ack+start together goes to IDLE
        s0 = n_starts;
        for (int c = 0; c < 20; c++) begin
            start = (c == 10);
            @(negedge clk);
            chk("hold_valid", {31'h0, lv_r}, 32'h1);
        end
        start = 1'b0;
        chk("hold_no_launch", 32'(n_starts - s0), 32'h0);
        layer_ack = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        layer_ack = 1'b0;
        start     = 1'b0;
        chk("ack_start_idle", {31'h0, busy_r}, 32'h0);
        @(negedge clk);
        chk("ack_start_dropped", {31'h0, busy_r}, 32'h0);
        chk_bufs("after_ack");

        // Next layer restarts at index 0 (checked in run_layer)
        for (int i = 0; i < M; i++) begin
            v[i] = 16'(16'hff00 + i);
            l[i] = 1;
        end
        run_layer(v, l, 1'b0, 1'b1, -1);

        // Reset in WAIT at idx 2, then a full layer
        for (int i = 0; i < M; i++) begin
            v[i] = 16'(100 + i);
            l[i] = 2;
        end
        run_layer(v, l, 1'b0, 1'b0, 2);
        @(negedge clk);
        run_layer(v, l, 1'b0, 1'b1, -1);

        // Zero-latency neurons: 2*M cycles launch to done
        for (int i = 0; i < M; i++) begin
            v[i] = 16'(i - 2);
            l[i] = 1;
        end
        run_layer(v, l, 1'b0, 1'b1, -1);

        // Randomized layers against the reference model
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < M; i++) begin
                v[i] = 16'($urandom);
                l[i] = $urandom_range(1, 5);
            end
            run_layer(v, l, 1'($urandom_range(0, 1)), 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
